// File: rtl/pulse_train_generator_if.sv
// Control, timing and status bundle between a pulse-train client and pulse_train_generator.
interface pulse_train_generator_if #(
  parameter int NUM_SIG = 8
);
  logic               start;
  logic               stop;
  logic [NUM_SIG-1:0] channel_mask;
  logic [31:0]        period;
  logic [31:0]        high_cycles;
  logic [31:0]        num_pulses;
  logic [NUM_SIG-1:0] output_signals;
  logic               busy;
  logic               done;
  logic               cfg_error;
  logic [31:0]        pulses_sent;

  modport master (
    output start, stop, channel_mask, period, high_cycles, num_pulses,
    input  output_signals, busy, done, cfg_error, pulses_sent
  );

  modport slave (
    input  start, stop, channel_mask, period, high_cycles, num_pulses,
    output output_signals, busy, done, cfg_error, pulses_sent
  );
endinterface

// File: rtl/pulse_train_generator.sv
// Burst generator: shared period/high-time/count drive the masked output lines.
// Define PTG_CONTINUOUS_EN to make num_pulses==0 a free-running burst ended by stop.
module pulse_train_generator #(
  parameter int NUM_SIG = 8
) (
  input  logic                     axi_clk,
  input  logic                     axi_reset,
  pulse_train_generator_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [NUM_SIG-1:0] mask_q, mask_d;
  logic [31:0]        period_q, period_d;
  logic [31:0]        high_q, high_d;
  logic [31:0]        num_q, num_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [31:0]        pulses_q, pulses_d;
  logic               stop_pend_q, stop_pend_d;
  logic [NUM_SIG-1:0] out_q, out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               cfg_ok;
  logic               burst_last;

  always_comb begin
    cfg_ok = (bus.period >= 32'd2) && (bus.high_cycles != 32'd0) &&
             (bus.high_cycles < bus.period);
`ifndef PTG_CONTINUOUS_EN
    cfg_ok = cfg_ok && (bus.num_pulses != 32'd0);
`endif
  end

  // A zero count in free-run mode never matches, so the burst only ends on stop.
  always_comb begin
    burst_last = (pulses_q == num_q);
`ifdef PTG_CONTINUOUS_EN
    burst_last = burst_last && (num_q != 32'd0);
`endif
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    period_d    = period_q;
    high_d      = high_q;
    num_d       = num_q;
    cnt_d       = cnt_q;
    pulses_d    = pulses_q;
    stop_pend_d = stop_pend_q;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (cfg_ok) begin
            mask_d      = bus.channel_mask;
            period_d    = bus.period;
            high_d      = bus.high_cycles;
            num_d       = bus.num_pulses;
            cnt_d       = bus.high_cycles - 32'd1;
            pulses_d    = 32'd1;
            stop_pend_d = 1'b0;
            state_d     = S_HIGH;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_HIGH: begin
        if (bus.stop) stop_pend_d = 1'b1;
        // A stop seen in HIGH lets the high phase finish, then skips LOW.
        if (cnt_q == 32'd0) begin
          if (bus.stop || stop_pend_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOW;
            cnt_d   = period_q - high_q - 32'd1;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_LOW: begin
        if (bus.stop) begin
          state_d = S_DONE;
        end else if (cnt_q == 32'd0) begin
          if (burst_last) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_HIGH;
            cnt_d    = high_q - 32'd1;
            pulses_d = pulses_q + 32'd1;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    out_d  = (state_d == S_HIGH) ? mask_d : '0;
    busy_d = (state_d == S_HIGH) || (state_d == S_LOW);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      state_q     <= S_IDLE;
      mask_q      <= '0;
      period_q    <= '0;
      high_q      <= '0;
      num_q       <= '0;
      cnt_q       <= '0;
      pulses_q    <= '0;
      stop_pend_q <= 1'b0;
      out_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      period_q    <= period_d;
      high_q      <= high_d;
      num_q       <= num_d;
      cnt_q       <= cnt_d;
      pulses_q    <= pulses_d;
      stop_pend_q <= stop_pend_d;
      out_q       <= out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.output_signals = out_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.cfg_error      = err_q;
  assign bus.pulses_sent    = pulses_q;

endmodule

// File: tb/tb_pulse_train_generator.sv
// Directed bench for pulse_train_generator with a cycle-by-cycle expected-value queue.
module tb_pulse_train_generator;
  localparam int NS = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pulse_train_generator_if #(.NUM_SIG(NS)) bus ();
  pulse_train_generator #(.NUM_SIG(NS)) dut (
    .axi_clk   (clk),
    .axi_reset (rst),
    .bus       (bus.slave)
  );

  typedef struct {
    logic [NS-1:0] out;
    logic          busy;
    logic          done;
    logic          err;
    logic [31:0]   ps;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_ps = '0;
  int          edges[NS];
  logic [NS-1:0] prev_out = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push_exp(input logic [NS-1:0] o, input logic b, input logic d,
                                   input logic e, input logic [31:0] p);
    exp_t x;
    x.out = o; x.busy = b; x.done = d; x.err = e; x.ps = p;
    q.push_back(x);
  endfunction

  // Advance to mid-cycle, track rising edges, compare against the next queued entry.
  task automatic step();
    exp_t x;
    @(negedge clk);
    for (int i = 0; i < NS; i++)
      if (bus.output_signals[i] && !prev_out[i]) edges[i]++;
    prev_out = bus.output_signals;
    if (q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL queue: observed empty expected entry");
    end else begin
      x = q.pop_front();
      chk("out",  {{(32-NS){1'b0}}, bus.output_signals}, {{(32-NS){1'b0}}, x.out});
      chk("busy", {31'd0, bus.busy},      {31'd0, x.busy});
      chk("done", {31'd0, bus.done},      {31'd0, x.done});
      chk("err",  {31'd0, bus.cfg_error}, {31'd0, x.err});
      chk("ps",   bus.pulses_sent, x.ps);
    end
  endtask

  // Start at cycle 0; optional stop driven during cycle s (0 = none).
  // poke: disturb inputs mid-burst and issue starts while busy and in DONE.
  task automatic run_burst(input logic [NS-1:0] m, input int unsigned p, input int unsigned h,
                           input int unsigned n, input int unsigned s, input bit poke);
    int unsigned d, ds, k;
    d = (n == 0) ? 32'hFFFF_FFFF : 1 + n * p;
    if (s != 0) begin
      k  = (s - 1) / p;
      ds = (((s - 1) % p) < h) ? (1 + k * p + h) : (s + 1);
      if (ds < d) d = ds;
    end
    for (int unsigned c = 1; c < d; c++)
      push_exp((((c - 1) % p) < h) ? m : '0, 1'b1, 1'b0, 1'b0, (c - 1) / p + 1);
    last_ps = (d - 2) / p + 1;
    push_exp('0, 1'b0, 1'b1, 1'b0, last_ps);
    push_exp('0, 1'b0, 1'b0, 1'b0, last_ps);

    bus.channel_mask = m; bus.period = p; bus.high_cycles = h; bus.num_pulses = n;
    bus.start = 1'b1;
    for (int unsigned c = 1; c <= d + 1; c++) begin
      step();
      bus.start = 1'b0;
      bus.stop  = (c == s);
      if (poke) begin
        if (c == 1) begin
          bus.channel_mask = '1; bus.period = 3; bus.high_cycles = 1; bus.num_pulses = 1;
        end
        if (c == 3) begin
          bus.start = 1'b1; bus.period = 0;
        end
        if (c == d) begin
          bus.start = 1'b1; bus.period = 4; bus.high_cycles = 2; bus.num_pulses = 1;
        end
      end
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  task automatic reject(input int unsigned p, input int unsigned h, input int unsigned n);
    bus.channel_mask = '1; bus.period = p; bus.high_cycles = h; bus.num_pulses = n;
    bus.start = 1'b1;
    push_exp('0, 1'b0, 1'b0, 1'b1, last_ps);
    push_exp('0, 1'b0, 1'b0, 1'b0, last_ps);
    step();
    bus.start = 1'b0;
    step();
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.channel_mask = '0;
    bus.period = '0; bus.high_cycles = '0; bus.num_pulses = '0;
    for (int i = 0; i < NS; i++) edges[i] = 0;

    repeat (3) @(negedge clk);
    chk("rst_out",  {{(32-NS){1'b0}}, bus.output_signals}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_err",  {31'd0, bus.cfg_error}, 32'd0);
    chk("rst_ps",   bus.pulses_sent, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic burst with input disturbances, plus loopback edge count per line.
    run_burst(8'h05, 4, 2, 3, 0, 1'b1);
    for (int i = 0; i < NS; i++)
      chk($sformatf("edges%0d", i), edges[i], (i == 0 || i == 2) ? 32'd3 : 32'd0);

    reject(4, 4, 3);
    reject(1, 1, 0);
    reject(5, 0, 2);
    reject(5, 6, 2);
`ifndef PTG_CONTINUOUS_EN
    reject(4, 2, 0);
`endif

    run_burst(8'hA5, 10, 5, 100, 23, 1'b0);
    run_burst(8'h81, 6, 2, 5, 4, 1'b0);
    run_burst(8'hFF, 2, 1, 4, 0, 1'b0);

    // Reset mid-burst at cycle 7, then a clean burst.
    bus.channel_mask = 8'h05; bus.period = 4; bus.high_cycles = 2; bus.num_pulses = 3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_out",  {{(32-NS){1'b0}}, bus.output_signals}, 32'd0);
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_ps",   bus.pulses_sent, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_ps = '0;
    prev_out = '0;
    run_burst(8'h05, 4, 2, 3, 0, 1'b0);

`ifdef PTG_CONTINUOUS_EN
    run_burst(8'h0F, 2, 1, 0, 1000, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
